// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised synchronous up/down counter.
// Supports programmable width and terminal value, direction control, parallel
// load (clamped to MAX_VAL), count enable and wrap/saturate mode. It provides a
// combinational terminal-count flag and a registered one-cycle wrap pulse.
// Optional build macro COUNTER_PRESCALE_EN adds an enable prescaler. With the
// prescaler, the counter steps once every PRESCALE enabled cycles.
module updown_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam bit PARAMS_OK = (WIDTH >= 2) && (MAX_VAL >= 1) &&
                             (MAX_VAL <= 2**WIDTH-1) && (PRESCALE >= 2);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("updown_counter_mod: illegal WIDTH/MAX_VAL/PRESCALE combination");
    end
  endgenerate

  // Clamp a load request into the legal count range 0..MAX_VAL.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // One counting step. The result is {wrap_flag, next_count}.
  // The ">=" on the upper bound keeps the next value inside 0..MAX_VAL.
  function automatic logic [WIDTH:0] step_value(input logic [WIDTH-1:0] c,
                                                input logic             dir_up,
                                                input logic             sat_mode);
    logic [WIDTH:0] r;
    r = {1'b0, c};
    if (dir_up) begin
      if (c >= MAX_V) begin
        if (!sat_mode) r = {1'b1, {WIDTH{1'b0}}};
      end else begin
        r = {1'b0, c + WIDTH'(1)};
      end
    end else begin
      if (c == '0) begin
        if (!sat_mode) r = {1'b1, MAX_V};
      end else begin
        r = {1'b0, c - WIDTH'(1)};
      end
    end
    return r;
  endfunction

  logic           step;
  logic [WIDTH:0] stepped;

`ifdef COUNTER_PRESCALE_EN
  localparam int              PS_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps;

  // Prescaler: advances on enabled non-load cycles, freezes when en=0, cleared by load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps <= '0;
    end else if (load) begin
      ps <= '0;
    end else if (en) begin
      ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
    end
  end

  assign step = en && !load && (ps == PS_LAST);
`else
  assign step = en && !load;
`endif

  assign stepped = step_value(count, up, sat);

  // Counter state: load has priority over a step; otherwise hold. wrap only pulses on a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= clamp_load(load_val);
      wrap  <= 1'b0;
    end else if (step) begin
      count <= stepped[WIDTH-1:0];
      wrap  <= stepped[WIDTH];
    end else begin
      wrap  <= 1'b0;
    end
  end

  // Terminal count follows the current direction; the only combinational input-to-output path.
  assign tc = up ? (count == MAX_V) : (count == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Testbench for updown_counter_mod with WIDTH=4, MAX_VAL=9, PRESCALE=4.
// Applies table vectors through a scoreboard queue, plus hand-written reset and tc sequences.
// The prescale sequence replaces the vector table when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_mod;

  localparam int WIDTH    = 4;
  localparam int MAX_VAL  = 9;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  updown_counter_mod #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .sat     (sat),
    .count   (count),
    .tc      (tc),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] c;
    logic             w;
    logic             t;
  } exp_t;

  typedef struct {
    string            name;
    logic             l;
    logic [WIDTH-1:0] lv;
    logic             e;
    logic             u;
    logic             s;
    logic [WIDTH-1:0] ec;
    logic             ew;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, compare after the edge.
  task automatic apply(input string name, input logic l, input logic [WIDTH-1:0] lv,
                       input logic e, input logic u, input logic s,
                       input logic [WIDTH-1:0] ec, input logic ew);
    exp_t x;
    load = l; load_val = lv; en = e; up = u; sat = s;
    x.c = ec;
    x.w = ew;
    x.t = u ? (ec == WIDTH'(MAX_VAL)) : (ec == '0);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      x = sb.pop_front();
      check({name, " count"}, int'(count), int'(x.c));
      check({name, " wrap"},  int'(wrap),  int'(x.w));
      check({name, " tc"},    int'(tc),    int'(x.t));
    end
  endtask

  task automatic add_vec(input string name, input logic l, input logic [WIDTH-1:0] lv,
                         input logic e, input logic u, input logic s,
                         input logic [WIDTH-1:0] ec, input logic ew);
    vec_t v;
    v.name = name; v.l = l; v.lv = lv; v.e = e; v.u = u; v.s = s; v.ec = ec; v.ew = ew;
    vecs.push_back(v);
  endtask

  // Assert reset mid-cycle and check it acts before the next edge, then hold it 3 clocks.
  task automatic mid_cycle_reset(input string name);
    #3;
    reset = 1'b1;
    #1;
    check({name, " async count"}, int'(count), 0);
    check({name, " async wrap"},  int'(wrap),  0);
    en = 1'b1; up = 1'b1; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check({name, " held count"}, int'(count), 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; sat = 1'b0;
    #1;
    check("reset count", int'(count), 0);
    check("reset wrap",  int'(wrap),  0);
    check("reset tc",    int'(tc),    0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset with count=5 in progress
    apply("load5", 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
    mid_cycle_reset("rst5");

`ifndef COUNTER_PRESCALE_EN
    // Reset while the wrap pulse is high
    apply("ld0",    1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    apply("dnwrap", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1);
    mid_cycle_reset("rstwrap");

    add_vec("start", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i <= 12; i++)
      add_vec($sformatf("upwrap%0d", i), 1'b0, 4'd0, 1'b1, 1'b1, 1'b0,
              4'((i == 10) ? 0 : (i > 10 ? i - 10 : i)), (i == 10));
    add_vec("ld2",     1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    add_vec("dnsat1",  1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    add_vec("dnsat2",  1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    add_vec("dnsat3",  1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    add_vec("dnsat4",  1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    add_vec("ldclamp", 1'b1, 4'd14, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0);
    add_vec("ld3",     1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
    add_vec("ld9",     1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
    add_vec("upsat",   1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
    add_vec("flip",    1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8, 1'b0);
    for (int i = 1; i <= 4; i++)
      add_vec($sformatf("hold%0d", i), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
    add_vec("ld0b",    1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    add_vec("dnwrap2", 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9, 1'b1);
    add_vec("wrapend", 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd9, 1'b0);
    add_vec("ld15",    1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0);
    add_vec("upwrap2", 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    add_vec("ld4",     1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 4'd4, 1'b0);

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u, vecs[i].s,
            vecs[i].ec, vecs[i].ew);
`else
    // Prescaled stepping: one step every PRESCALE enabled cycles
    apply("psld0", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i <= 12; i++)
      apply($sformatf("ps%0d", i), 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'(i / PRESCALE), 1'b0);
    apply("psen1",  1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
    apply("psen2",  1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
    apply("psoff1", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
    apply("psoff2", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
    apply("psen3",  1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
    apply("psen4",  1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
    apply("psen5",  1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
    apply("psld7",  1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0);
    apply("psa1",   1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0);
    apply("psa2",   1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0);
    apply("psa3",   1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0);
    apply("psa4",   1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd8, 1'b0);
    apply("psld9",  1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
    for (int i = 1; i <= 3; i++)
      apply($sformatf("psw%0d", i), 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0);
    apply("pswrap", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
`endif

    // tc follows up combinationally within a cycle
    apply("ld9tc", 1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
    #1; up = 1'b0; #1;
    check("tc up0 at 9", int'(tc), 0);
    up = 1'b1; #1;
    check("tc up1 at 9", int'(tc), 1);
    apply("ld0tc", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    #1; up = 1'b0; #1;
    check("tc up0 at 0", int'(tc), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
